// File: rtl/pbus_arbiter_pkg.sv
// Shared definitions for the peripheral-bus arbiter: bus geometry,
// FSM state encoding and the request field bundle.
package pbus_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 4;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } pbus_state_e;

  // Everything that must be forwarded to the target with a request.
  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
  } pbus_req_t;

endpackage

// File: rtl/pbus_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not own
// the bus most recently wins.
module pbus_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_valid
);

  // Lone requester wins outright; a tie goes to the one that was not last.
  always_comb begin
    o_valid = |i_req;
    o_grant = (&i_req) ? ~i_last : i_req[1];
  end

endmodule

// File: rtl/pbus_arbiter.sv
// Two-requester arbiter for a single peripheral-bus target. One request
// at a time is granted round-robin, forwarded to the target, and the
// target's response is steered back to the owner. A watchdog converts a
// hung target into a fault response and then drains the late response.
module pbus_arbiter
  import pbus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstn,

  input  logic [XLEN-1:0]      m0_addr,
  input  logic                 m0_w_rb,
  input  logic [ACC_W-1:0]     m0_acc,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  input  logic                 m0_req,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  output logic                 m0_resp,
  output logic                 m0_fault,

  input  logic [XLEN-1:0]      m1_addr,
  input  logic                 m1_w_rb,
  input  logic [ACC_W-1:0]     m1_acc,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  input  logic                 m1_req,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 m1_resp,
  output logic                 m1_fault,

  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [ACC_W-1:0]     s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  output logic                 s_req,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_resp,
  input  logic                 s_fault,

  output logic                 grant
);

  // Last BUSY count before the watchdog fires; unused when TIMEOUT is 0.
  localparam int               TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam logic             TO_EN   = (TIMEOUT != 0);

  pbus_state_e          r_state, w_state_nxt;
  logic                 r_last;
  logic                 r_grant;
  logic                 r_sreq;
  logic [CNT_W-1:0]     r_cnt;
  pbus_req_t            r_sfld;

  logic [1:0]           w_req;
  logic                 w_pick;
  logic                 w_pick_vld;
  pbus_req_t            w_m0_fld, w_m1_fld, w_pick_fld;

  logic                 w_take;     // grant issued this cycle
  logic                 w_fin;      // target answered an owned transaction
  logic                 w_to;       // watchdog fires this cycle
  logic                 w_rsp;
  logic [BUS_WIDTH-1:0] w_rsp_data;
  logic                 w_rsp_fault;

  assign w_req    = {m1_req, m0_req};
  assign w_m0_fld = '{addr: m0_addr, w_rb: m0_w_rb, acc: m0_acc, wdata: m0_wdata};
  assign w_m1_fld = '{addr: m1_addr, w_rb: m1_w_rb, acc: m1_acc, wdata: m1_wdata};
  assign w_pick_fld = w_pick ? w_m1_fld : w_m0_fld;

  pbus_rr_pick u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_valid (w_pick_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and event decode. A target response in the watchdog's
  // final cycle wins over the timeout, so it is tested first.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_fin       = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_take      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_resp) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_to        = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Late response is swallowed; the requester was already answered.
        if (s_resp) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Response mux: the only combinational path to the requesters. The
  // non-owner always sees zeros, and so does the owner between responses.
  always_comb begin
    w_rsp       = w_fin | w_to;
    w_rsp_data  = w_fin ? s_rdata : '0;
    w_rsp_fault = w_fin ? s_fault : w_to;
    m0_resp     = w_rsp & ~r_grant;
    m1_resp     = w_rsp &  r_grant;
    m0_rdata    = m0_resp ? w_rsp_data : '0;
    m1_rdata    = m1_resp ? w_rsp_data : '0;
    m0_fault    = m0_resp & w_rsp_fault;
    m1_fault    = m1_resp & w_rsp_fault;
  end

  // Ownership tracking; last starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last  <= 1'b1;
      r_grant <= 1'b0;
    end else if (w_take) begin
      r_last  <= w_pick;
      r_grant <= w_pick;
    end
  end

  // Target request: held from the grant until the target answers,
  // including through a drain after a timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sreq <= 1'b0;
    else       r_sreq <= (w_state_nxt != ST_IDLE);
  end

  // Forwarded fields are captured once at grant and stay stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_sfld <= '0;
    else if (w_take) r_sfld <= w_pick_fld;
  end

  // Watchdog counter: cleared at grant, counts BUSY cycles without a
  // response. The timeout fires before it can wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       r_cnt <= '0;
    else if (w_take)                                 r_cnt <= '0;
    else if (r_state == ST_BUSY && !w_fin && !w_to)  r_cnt <= r_cnt + 1'b1;
  end

  assign s_req   = r_sreq;
  assign s_addr  = r_sfld.addr;
  assign s_w_rb  = r_sfld.w_rb;
  assign s_acc   = r_sfld.acc;
  assign s_wdata = r_sfld.wdata;
  assign grant   = r_grant;

endmodule

// File: tb/tb_pbus_arbiter.sv
// Randomized bench for pbus_arbiter against a transaction-level model:
// two requesters with random gaps and fields, a target with random
// latency (short, at the watchdog boundary, and hung past it), spurious
// idle responses, and an asynchronous reset in the middle of a transfer.
module tb_pbus_arbiter;
  import pbus_arbiter_pkg::*;

  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [XLEN-1:0]      m0_addr = '0, m1_addr = '0, s_addr;
  logic                 m0_w_rb = 1'b0, m1_w_rb = 1'b0, s_w_rb;
  logic [ACC_W-1:0]     m0_acc = '0, m1_acc = '0, s_acc;
  logic [BUS_WIDTH-1:0] m0_wdata = '0, m1_wdata = '0, s_wdata;
  logic                 m0_req = 1'b0, m1_req = 1'b0, s_req;
  logic [BUS_WIDTH-1:0] m0_rdata, m1_rdata, s_rdata = '0;
  logic                 m0_resp, m1_resp, s_resp = 1'b0;
  logic                 m0_fault, m1_fault, s_fault = 1'b0;
  logic                 grant;

  always #5 clk = ~clk;

  pbus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata),
    .m0_req(m0_req), .m0_rdata(m0_rdata), .m0_resp(m0_resp), .m0_fault(m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata),
    .m1_req(m1_req), .m1_rdata(m1_rdata), .m1_resp(m1_resp), .m1_fault(m1_fault),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_req(s_req), .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault),
    .grant(grant)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester stimulus state
  bit                   rq[2];
  logic [XLEN-1:0]      ad[2];
  logic                 wr[2];
  logic [ACC_W-1:0]     ac[2];
  logic [BUS_WIDTH-1:0] wd[2];
  int                   gap[2];
  bit                   rsp_prev[2];

  // Target stimulus for the current cycle
  bit                   srsp;
  logic [BUS_WIDTH-1:0] srd;
  bit                   sft;

  // Transaction-level model
  bit                   open;       // target holds a request
  bit                   answered;   // owner already got a timeout fault
  int                   age;        // 1 = first cycle s_req is high
  int                   lat;        // cycle at which the target will answer
  bit                   own, lastw, gnt_exp;
  logic [XLEN-1:0]      sad;
  logic                 swr;
  logic [ACC_W-1:0]     sac;
  logic [BUS_WIDTH-1:0] swd;
  bit                   er[2];
  bit                   ef;
  logic [BUS_WIDTH-1:0] ed;

  task automatic new_req(input int i);
    rq[i] = 1'b1;
    ad[i] = $urandom;
    wr[i] = 1'($urandom % 2);
    ac[i] = ACC_W'($urandom % BUS_ACC_CNT);
    wd[i] = $urandom;
  endtask

  task automatic apply();
    m0_req = rq[0]; m0_addr = ad[0]; m0_w_rb = wr[0]; m0_acc = ac[0]; m0_wdata = wd[0];
    m1_req = rq[1]; m1_addr = ad[1]; m1_w_rb = wr[1]; m1_acc = ac[1]; m1_wdata = wd[1];
    s_resp = srsp; s_rdata = srd; s_fault = sft;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (rsp_prev[i]) begin
        if ($urandom % 2 == 0) new_req(i);
        else begin rq[i] = 1'b0; gap[i] = $urandom % 6; end
      end else if (!rq[i]) begin
        if (gap[i] == 0) new_req(i);
        else gap[i]--;
      end
    end
    srsp = open ? (age == lat) : ($urandom % 8 == 0);
    srd  = $urandom;
    sft  = 1'($urandom % 2);
    apply();
  endtask

  task automatic check_outputs();
    logic [BUS_WIDTH-1:0] gd;
    bit gr, gf;
    er[0] = 1'b0; er[1] = 1'b0; ef = 1'b0; ed = '0;
    if (open && !answered) begin
      if (srsp) begin er[own] = 1'b1; ed = srd; ef = sft; end
      else if (age == TO) begin er[own] = 1'b1; ef = 1'b1; ed = '0; end
    end
    chk("s_req", s_req, open);
    if (open) begin
      chk("s_addr", s_addr, sad);
      chk("s_w_rb", s_w_rb, swr);
      chk("s_acc", s_acc, sac);
      chk("s_wdata", s_wdata, swd);
    end
    chk("grant", grant, gnt_exp);
    for (int i = 0; i < 2; i++) begin
      gr = (i == 0) ? m0_resp  : m1_resp;
      gf = (i == 0) ? m0_fault : m1_fault;
      gd = (i == 0) ? m0_rdata : m1_rdata;
      chk($sformatf("m%0d_resp", i), gr, er[i]);
      if (er[i] || (open && i != int'(own))) begin
        chk($sformatf("m%0d_fault", i), gf, er[i] ? ef : 1'b0);
        chk($sformatf("m%0d_rdata", i), gd, er[i] ? ed : '0);
      end
    end
  endtask

  task automatic update();
    int r;
    rsp_prev[0] = er[0];
    rsp_prev[1] = er[1];
    if (open) begin
      if (srsp) open = 1'b0;
      else if (!answered && age == TO) answered = 1'b1;
      age++;
    end else if (rq[0] || rq[1]) begin
      own      = (rq[0] && rq[1]) ? !lastw : rq[1];
      lastw    = own;
      gnt_exp  = own;
      open     = 1'b1;
      answered = 1'b0;
      age      = 1;
      sad = ad[own]; swr = wr[own]; sac = ac[own]; swd = wd[own];
      r = $urandom % 10;
      if (r < 6)       lat = 1 + $urandom % 5;
      else if (r == 6) lat = TO;
      else if (r == 7) lat = TO - 1;
      else             lat = TO + 1 + $urandom % 12;
    end
  endtask

  task automatic one_cycle();
    @(posedge clk);
    #1;
    drive();
    #1;
    check_outputs();
    update();
  endtask

  // Reset the model and release reset with both requesters pending, so
  // the first decision is a tie that m0 must win.
  task automatic release_reset();
    open = 1'b0; answered = 1'b0; age = 0; lat = 0;
    lastw = 1'b1; gnt_exp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rsp_prev[i] = 1'b0; gap[i] = 0; new_req(i);
    end
    srsp = 1'b0; srd = $urandom; sft = 1'b0;
    apply();
    rstn = 1'b1;
    #1;
    check_outputs();
    update();
  endtask

  initial begin
    int guard;
    // Reset values, with a target response present to show it is ignored.
    s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF; s_fault = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    #12;
    chk("rst_s_req", s_req, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_acc", s_acc, 0);
    chk("rst_s_w_rb", s_w_rb, 0);
    chk("rst_m0_resp", m0_resp, 0);
    chk("rst_m1_resp", m1_resp, 0);
    chk("rst_m0_fault", m0_fault, 0);
    chk("rst_m1_fault", m1_fault, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_grant", grant, 0);

    @(negedge clk);
    release_reset();
    for (int c = 0; c < 2500; c++) one_cycle();

    // Find a transfer in progress, then pull reset asynchronously.
    guard = 0;
    while (!(open && !answered && age >= 3) && guard < 200) begin
      one_cycle();
      guard++;
    end
    chk("midbusy_found", guard < 200, 1);
    #2;
    s_resp = 1'b1;
    rstn = 1'b0;
    #1;
    chk("arst_s_req", s_req, 0);
    chk("arst_m0_resp", m0_resp, 0);
    chk("arst_m1_resp", m1_resp, 0);
    chk("arst_grant", grant, 0);
    @(posedge clk);
    #3;
    release_reset();
    for (int c = 0; c < 2500; c++) one_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
